// File: rtl/rdata_subo_arb_pkg.sv
// rdata_subo_arb_pkg: shared FSM encodings and line/burst geometry for the read-data arbiter and its subordinate
// Exports LINE_W (line width), BEATS (beats per burst), WORD_W (beat width) and the arbiter state type.
package rdata_subo_arb_pkg;
  localparam int LINE_W = 128;
  localparam int BEATS  = 4;
  localparam int WORD_W = LINE_W / BEATS;
  typedef enum logic [1:0] {
    RARB_IDLE = 2'd0,
    RARB_GNT  = 2'd1,
    RARB_WAIT = 2'd2,
    RARB_DEFO = 2'd3
  } rarb_state_e;
endpackage

// File: rtl/rdata_subo_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible index at or above the pointer, wrapping
// Ports: i_elig eligible vector, i_ptr search start, o_found any eligible, o_idx picked index.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [1:0]      i_ptr,
  output logic            o_found,
  output logic [1:0]      o_idx
);
  // The winner is the eligible index with the smallest wrapped distance from the pointer.
  always_comb begin
    int best, d;
    best    = NREQ;
    d       = 0;
    o_found = 1'b0;
    o_idx   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      d = (k - int'(i_ptr) + NREQ) % NREQ;
      if (i_elig[k] && d < best) begin
        best    = d;
        o_found = 1'b1;
        o_idx   = 2'(k);
      end
    end
  end
endmodule

// File: rtl/rdata_subo_arb.sv
// rdata_subo_arb: round-robin arbiter sharing one level-valid read-data subordinate between NREQ line sources
// Ports: req_valid/req_id/req_data per-source request, id and 128-bit line; req_done one-cycle completion pulse;
// rdata_s_valid/rdata_s_id/rdata_s_data latched side-interface to the subordinate; finish_rdata_s burst end;
// busy high while granted; gnt_idx current or last grant.
module rdata_subo_arb
  import rdata_subo_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IDW-1:0]    req_id,
  input  logic [NREQ*LINE_W-1:0] req_data,
  output logic [NREQ-1:0]        req_done,
  output logic                   rdata_s_valid,
  output logic [IDW-1:0]         rdata_s_id,
  output logic [LINE_W-1:0]      rdata_s_data,
  input  logic                   finish_rdata_s,
  output logic                   busy,
  output logic [1:0]             gnt_idx
);
  rarb_state_e       r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_gnt;
  logic [NREQ-1:0]   r_skip;
  logic [NREQ-1:0]   r_done;
  logic              r_valid;
  logic              r_err;
  logic [IDW-1:0]    r_id;
  logic [LINE_W-1:0] r_data;
  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_gnt_oh;
  logic              w_found;
  logic [1:0]        w_idx;
  logic [1:0]        w_nxt_ptr;
  // A just-finished source still shows req_valid for one cycle; the skip mask hides it.
  assign w_elig    = req_valid & ~r_skip;
  assign w_gnt_oh  = NREQ'(1) << r_gnt;
  assign w_nxt_ptr = (r_gnt == 2'(NREQ-1)) ? 2'd0 : r_gnt + 2'd1;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RARB_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_skip  <= '0;
      r_done  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        RARB_IDLE: begin
          r_skip <= '0;
          if (finish_rdata_s) r_err <= 1'b1;
          if (w_found) begin
            r_gnt   <= w_idx;
            r_id    <= req_id[IDW*int'(w_idx) +: IDW];
            r_data  <= req_data[LINE_W*int'(w_idx) +: LINE_W];
            r_valid <= 1'b1;
            r_state <= RARB_GNT;
          end
        end
        RARB_GNT: begin
          if (finish_rdata_s) r_err <= 1'b1;
          r_state <= RARB_WAIT;
        end
        RARB_WAIT: begin
          // Valid drops on the finish edge so the level-sensitive subordinate does not restart.
          if (finish_rdata_s) begin
            r_valid <= 1'b0;
            r_done  <= w_gnt_oh;
            r_ptr   <= w_nxt_ptr;
            r_skip  <= w_gnt_oh;
            r_state <= RARB_IDLE;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end
  assign req_done      = r_done;
  assign rdata_s_valid = r_valid;
  assign rdata_s_id    = r_id;
  assign rdata_s_data  = r_data;
  assign gnt_idx       = r_gnt;
  assign busy          = (r_state == RARB_GNT) || (r_state == RARB_WAIT);
  // A finish outside WAIT means the subordinate and arbiter disagree about the burst.
  assert property (@(posedge clk) disable iff (!rst_n) !r_err);
endmodule

// File: tb/tb_rdata_subo_arb.sv
module tb_rdata_subo_arb;
  import rdata_subo_arb_pkg::*;
  localparam int NREQ = 2;
  localparam int IDW  = 4;
  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*IDW-1:0]    req_id;
  logic [NREQ*LINE_W-1:0] req_data;
  logic [NREQ-1:0]        req_done;
  logic                   rdata_s_valid;
  logic [IDW-1:0]         rdata_s_id;
  logic [LINE_W-1:0]      rdata_s_data;
  logic                   finish_rdata_s;
  logic                   busy;
  logic [1:0]             gnt_idx;
  logic                   s_act;
  logic [1:0]             s_beat;
  logic                   rready;
  typedef struct {
    logic [1:0]        idx;
    logic [IDW-1:0]    id;
    logic [LINE_W-1:0] data;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [LINE_W-1:0] D0 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [LINE_W-1:0] DA = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
  localparam logic [LINE_W-1:0] DB = 128'hB0000001_B0000002_B0000003_B0000004;
  localparam logic [LINE_W-1:0] DC = 128'hC0FFEE00_C0FFEE01_C0FFEE02_C0FFEE03;
  localparam logic [LINE_W-1:0] DD = 128'hDEAD0000_DEAD1111_DEAD2222_DEAD3333;
  localparam logic [LINE_W-1:0] DE = 128'hE1E2E3E4_E5E6E7E8_E9EAEBEC_EDEEEFE0;
  localparam logic [LINE_W-1:0] DF = 128'hF00DF00D_12345678_9ABCDEF0_0F0F0F0F;
  localparam logic [LINE_W-1:0] DG = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [LINE_W-1:0] DH = 128'h55555555_AAAAAAAA_5A5A5A5A_A5A5A5A5;
  localparam logic [LINE_W-1:0] DI = 128'h11112222_33334444_55556666_77778888;

  rdata_subo_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_id         (req_id),
    .req_data       (req_data),
    .req_done       (req_done),
    .rdata_s_valid  (rdata_s_valid),
    .rdata_s_id     (rdata_s_id),
    .rdata_s_data   (rdata_s_data),
    .finish_rdata_s (finish_rdata_s),
    .busy           (busy),
    .gnt_idx        (gnt_idx)
  );

  always #5 clk = ~clk;

  // Level-valid subordinate: starts a 4-beat burst whenever it is idle and sees valid high.
  assign finish_rdata_s = s_act && rready && (s_beat == 2'd3);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_act  <= 1'b0;
      s_beat <= 2'd0;
    end else if (!s_act) begin
      s_act  <= rdata_s_valid;
      s_beat <= 2'd0;
    end else if (rready) begin
      s_act  <= (s_beat != 2'd3);
      s_beat <= s_beat + 2'd1;
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred with no expectation pending", nm);
  endtask

  // Monitor: each beat and each done pulse is checked against the front of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (s_act && rready) begin
        if (q.size() == 0) fail("beat_without_grant");
        else begin
          check("beat_id", 128'(rdata_s_id), 128'(q[0].id));
          check("beat_data", 128'(rdata_s_data[32*s_beat +: 32]), 128'(q[0].data[32*s_beat +: 32]));
          check("beat_gnt_idx", 128'(gnt_idx), 128'(q[0].idx));
        end
      end
      if (req_done != '0) begin
        if (q.size() == 0) fail("done_without_grant");
        else begin
          check("done_onehot", 128'(req_done), 128'(NREQ'(1) << q[0].idx));
          check("valid_low_after_finish", 128'(rdata_s_valid), 128'(0));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [IDW-1:0] id, input logic [LINE_W-1:0] d);
    req_id[k*IDW +: IDW]       = id;
    req_data[k*LINE_W +: LINE_W] = d;
  endtask

  task automatic push(input int k, input logic [IDW-1:0] id, input logic [LINE_W-1:0] d);
    exp_t e;
    e.idx  = 2'(k);
    e.id   = id;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic wait_done(input int k, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(negedge clk);
      seen = req_done[k];
    end
    check($sformatf("done_seen_src%0d", k), 128'(seen), 128'(1));
    @(posedge clk);
    #1;
    if (drop) req_valid[k] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 128'(rdata_s_valid), 128'(0));
    check({tag, "_id"}, 128'(rdata_s_id), 128'(0));
    check({tag, "_data"}, rdata_s_data, 128'(0));
    check({tag, "_done"}, 128'(req_done), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_gnt_idx"}, 128'(gnt_idx), 128'(0));
  endtask

  initial begin
    req_valid = '0;
    req_id    = '0;
    req_data  = '0;
    rready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    // single request: valid one cycle after the request
    set_src(0, 4'h5, D0);
    push(0, 4'h5, D0);
    req_valid[0] = 1'b1;
    tick();
    check("lat_valid", 128'(rdata_s_valid), 128'(1));
    check("lat_busy", 128'(busy), 128'(1));
    check("lat_id", 128'(rdata_s_id), 128'(4'h5));
    check("lat_data", rdata_s_data, D0);
    wait_done(0, 1'b1);
    repeat (3) tick();
    // contention from reset: 0 then 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    set_src(0, 4'h1, DA);
    set_src(1, 4'h2, DB);
    push(0, 4'h1, DA);
    push(1, 4'h2, DB);
    req_valid = 2'b11;
    tick();
    check("cont_gnt0", 128'(gnt_idx), 128'(0));
    wait_done(0, 1'b1);
    check("cont_gnt1", 128'(gnt_idx), 128'(1));
    check("cont_valid1", 128'(rdata_s_valid), 128'(1));
    wait_done(1, 1'b1);
    repeat (2) tick();
    // back-to-back: source 0 keeps requesting, source 1 must still go next
    set_src(0, 4'h3, DC);
    set_src(1, 4'h4, DD);
    push(0, 4'h3, DC);
    push(1, 4'h4, DD);
    req_valid = 2'b11;
    wait_done(0, 1'b0);
    set_src(0, 4'h6, DE);
    push(0, 4'h6, DE);
    check("b2b_gnt1", 128'(gnt_idx), 128'(1));
    wait_done(1, 1'b1);
    check("b2b_gnt0", 128'(gnt_idx), 128'(0));
    wait_done(0, 1'b1);
    repeat (2) tick();
    // backpressure: rready low 10 cycles after beat 0
    set_src(1, 4'h9, DF);
    push(1, 4'h9, DF);
    req_valid[1] = 1'b1;
    repeat (3) tick();
    rready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_valid", 128'(rdata_s_valid), 128'(1));
      check("bp_busy", 128'(busy), 128'(1));
      check("bp_id", 128'(rdata_s_id), 128'(4'h9));
      check("bp_data", rdata_s_data, DF);
      check("bp_no_done", 128'(req_done), 128'(0));
    end
    rready = 1'b1;
    wait_done(1, 1'b1);
    repeat (2) tick();
    // reset during beat 2
    set_src(0, 4'h3, DG);
    push(0, 4'h3, DG);
    req_valid[0] = 1'b1;
    for (int c = 0; c < 20 && !(s_act && s_beat == 2'd2); c++) @(negedge clk);
    check("rst_reached_beat2", 128'(s_beat), 128'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    q.delete();
    req_valid = '0;
    tick();
    tick();
    check("midrst_hold_done", 128'(req_done), 128'(0));
    rst_n = 1'b1;
    tick();
    set_src(1, 4'hA, DH);
    push(1, 4'hA, DH);
    req_valid[1] = 1'b1;
    tick();
    check("postrst_valid", 128'(rdata_s_valid), 128'(1));
    check("postrst_gnt", 128'(gnt_idx), 128'(1));
    wait_done(1, 1'b1);
    repeat (2) tick();
    // source changes its line mid-burst; beats must carry the latched line
    set_src(0, 4'h7, DI);
    push(0, 4'h7, DI);
    req_valid[0] = 1'b1;
    repeat (3) tick();
    set_src(0, 4'h8, ~DI);
    wait_done(0, 1'b1);
    repeat (4) tick();
    check("scoreboard_empty", 128'(q.size()), 128'(0));
    check("final_idle", 128'(busy), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
